// File: rtl/nn_train_pkg.sv
// Shared types and constants for the 15-class argmax trainer: class index,
// layer activation format, trainer FSM states and a target-vector helper.
package nn_train_pkg;

    localparam int N_CLASSES = 15;
    localparam int CLASS_W   = 4;

    typedef logic [CLASS_W-1:0] class_idx_t;

    // Unsigned fraction in [0, 1]; all-ones is full scale.
    typedef logic [7:0] zero2one_t;
    localparam zero2one_t ZERO2ONE_ONE = 8'hFF;

    typedef zero2one_t [N_CLASSES-1:0] layer_vec_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EVAL   = 3'd1,
        S_WAIT   = 3'd2,
        S_SCAN   = 3'd3,
        S_LEARN  = 3'd4,
        S_RESULT = 3'd5
    } trainer_state_t;

    // One-hot full-scale target; an out-of-range label yields all zero.
    function automatic layer_vec_t target_vec(input class_idx_t label);
        layer_vec_t v;
        for (int i = 0; i < N_CLASSES; i++) begin
            v[i] = (label == class_idx_t'(i)) ? ZERO2ONE_ONE : 8'h00;
        end
        return v;
    endfunction

endpackage

// File: rtl/argmax_seq_15.sv
// Sequential arg-max over a 15-entry activation snapshot: one compare per
// cycle, strictly-greater so ties keep the lowest index.
module argmax_seq_15
    import nn_train_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  layer_vec_t data_in,
    output logic       done,
    output class_idx_t max_idx
);

    localparam class_idx_t LAST_IDX = class_idx_t'(N_CLASSES - 1);

    layer_vec_t data_r;
    zero2one_t  best_val_r;
    class_idx_t best_idx_r;
    class_idx_t idx_r;
    logic       running_r;
    zero2one_t  cur_s;
    logic       greater_s;

    assign cur_s     = data_r[idx_r];
    assign greater_s = (cur_s > best_val_r);

    // done coincides with the last compare so the caller can leave on that edge.
    assign done    = running_r && (idx_r == LAST_IDX);
    assign max_idx = greater_s ? idx_r : best_idx_r;

    // Snapshot load and running-maximum update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_r     <= '0;
            best_val_r <= 8'h00;
            best_idx_r <= 4'd0;
            idx_r      <= 4'd1;
            running_r  <= 1'b0;
        end else if (load) begin
            data_r     <= data_in;
            best_val_r <= data_in[0];
            best_idx_r <= 4'd0;
            idx_r      <= 4'd1;
            running_r  <= 1'b1;
        end else if (running_r) begin
            if (greater_s) begin
                best_val_r <= cur_s;
                best_idx_r <= idx_r;
            end else begin
                best_val_r <= best_val_r;
                best_idx_r <= best_idx_r;
            end
            if (idx_r == LAST_IDX) begin
                running_r <= 1'b0;
                idx_r     <= 4'd1;
            end else begin
                running_r <= 1'b1;
                idx_r     <= idx_r + 4'd1;
            end
        end else begin
            running_r <= 1'b0;
        end
    end

endmodule

// File: rtl/layer15_argmax_trainer.sv
// Trainer control for the 15-neuron layer: evaluate, arg-max, one-hot learn,
// result handshake and saturating accuracy counters.
// Optional macro SKIP_CORRECT_LEARN_EN suppresses learning on correct samples.
module layer15_argmax_trainer
    import nn_train_pkg::*;
#(
    parameter int LAT   = 1,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  class_idx_t       sample_label,
    input  logic             train,
    output logic             layer_valid,
    output logic             layer_learn,
    input  layer_vec_t       layer_out,
    output layer_vec_t       expected_out,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output class_idx_t       result_class,
    output logic             result_correct,
    output logic             label_err,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] correct_count
);

    localparam logic [3:0] WAIT_INIT = 4'(LAT - 1);

    trainer_state_t state_r;
    class_idx_t     label_r;
    logic           train_r;
    logic [3:0]     wait_cnt_r;
    logic           scan_load_s;
    logic           scan_done_s;
    class_idx_t     scan_idx_s;
    logic           learn_ok_s;

    assign sample_ready = (state_r == S_IDLE);
    assign busy         = (state_r != S_IDLE);
    assign scan_load_s  = (state_r == S_WAIT) && (wait_cnt_r == 4'd0);

    argmax_seq_15 u_argmax (
        .clock   (clock),
        .reset   (reset),
        .load    (scan_load_s),
        .data_in (layer_out),
        .done    (scan_done_s),
        .max_idx (scan_idx_s)
    );

    // Learn condition evaluated on the final arg-max compare.
    always_comb begin
        learn_ok_s = train_r && !label_err;
`ifdef SKIP_CORRECT_LEARN_EN
        learn_ok_s = learn_ok_s && (scan_idx_s != label_r);
`else
        learn_ok_s = learn_ok_s;
`endif
    end

    // Trainer FSM with registered layer/result outputs and counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r        <= S_IDLE;
            label_r        <= 4'd0;
            train_r        <= 1'b0;
            wait_cnt_r     <= 4'd0;
            layer_valid    <= 1'b0;
            layer_learn    <= 1'b0;
            expected_out   <= '0;
            result_valid   <= 1'b0;
            result_class   <= 4'd0;
            result_correct <= 1'b0;
            label_err      <= 1'b0;
            sample_count   <= '0;
            correct_count  <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (sample_valid) begin
                        label_r      <= sample_label;
                        train_r      <= train;
                        label_err    <= (sample_label >= class_idx_t'(N_CLASSES));
                        expected_out <= target_vec(sample_label);
                        layer_valid  <= 1'b1;
                        state_r      <= S_EVAL;
                    end else begin
                        state_r      <= S_IDLE;
                    end
                end
                S_EVAL: begin
                    layer_valid <= 1'b0;
                    wait_cnt_r  <= WAIT_INIT;
                    state_r     <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt_r == 4'd0) begin
                        state_r    <= S_SCAN;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                S_SCAN: begin
                    if (scan_done_s) begin
                        result_class   <= scan_idx_s;
                        result_correct <= (scan_idx_s == label_r) && !label_err;
                        layer_learn    <= learn_ok_s;
                        layer_valid    <= learn_ok_s;
                        state_r        <= S_LEARN;
                    end else begin
                        state_r        <= S_SCAN;
                    end
                end
                S_LEARN: begin
                    layer_learn  <= 1'b0;
                    layer_valid  <= 1'b0;
                    result_valid <= 1'b1;
                    if (sample_count != {CNT_W{1'b1}}) begin
                        sample_count <= sample_count + CNT_W'(1);
                    end else begin
                        sample_count <= sample_count;
                    end
                    if (result_correct && (correct_count != {CNT_W{1'b1}})) begin
                        correct_count <= correct_count + CNT_W'(1);
                    end else begin
                        correct_count <= correct_count;
                    end
                    state_r <= S_RESULT;
                end
                S_RESULT: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        expected_out <= '0;
                        state_r      <= S_IDLE;
                    end else begin
                        state_r      <= S_RESULT;
                    end
                end
                default: begin
                    layer_valid  <= 1'b0;
                    layer_learn  <= 1'b0;
                    result_valid <= 1'b0;
                    state_r      <= S_IDLE;
                end
            endcase
        end
    end

endmodule
